yukle_sakla_birimi: RTL and testbench
=====================================

YUKLE_SAKLA_BIRIMI -- requirements
Module: yukle_sakla_birimi

Interface
REQ-001 SHALL have parameter KELIME_SAYISI, default 256, number of 32-bit words in the downstream data memory (power of two).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port istek_gecerli  input  1  core request valid.
REQ-005 SHALL have port istek_hazir  output  1  unit can accept a request.
REQ-006 SHALL have port istek_yaz  input  1  1 = store, 0 = load.
REQ-007 SHALL have port istek_funct3  input  3  RISC-V funct3 (size/sign).
REQ-008 SHALL have port istek_adres  input  32  byte address.
REQ-009 SHALL have port istek_veri  input  32  store data, LSB-aligned.
REQ-010 SHALL have port bellek_adres  output  32  word index to data memory.
REQ-011 SHALL have port bellek_veri  output  32  full merged write word to data memory.
REQ-012 SHALL have port bellege_yaz  output  1  data memory write enable.
REQ-013 SHALL have port bellek_veri_cikisi  input  32  combinational read word from data memory.
REQ-014 SHALL have port yanit_gecerli  output  1  one-cycle response pulse.
REQ-015 SHALL have port yanit_veri  output  32  load result (0 for stores and errors).
REQ-016 SHALL have port yanit_hata  output  1  request faulted; valid with yanit_gecerli.

Function
REQ-017 SHALL implement FSM BOSTA -> ERISIM -> YANIT -> BOSTA; istek_hazir = 1 only in BOSTA.
REQ-018 SHALL accept a request on the rising edge where istek_gecerli && istek_hazir, registering yaz, funct3, adres, veri; istek_gecerli outside BOSTA SHALL be ignored.
REQ-019 SHALL classify as fault: funct3 not in {000,001,010,100,101} for loads or not in {000,001,010} for stores; halfword with adres[0]=1; word with adres[1:0]!=0.
REQ-020 SHALL on a faulted request go BOSTA -> YANIT directly, never assert bellege_yaz, and present yanit_hata=1, yanit_veri=0.
REQ-021 SHALL in ERISIM drive bellek_adres = registered adres[log2(KELIME_SAYISI)+1:2], zero-extended; bellek_adres SHALL be 0 outside ERISIM.
REQ-022 SHALL for stores in ERISIM assert bellege_yaz for exactly one cycle with bellek_veri = bellek_veri_cikisi with the addressed lanes replaced: SB lane adres[1:0] from veri[7:0]; SH lanes adres[1]*2..+1 from veri[15:0]; SW full word.
REQ-023 SHALL for loads capture in ERISIM the addressed byte/halfword/word: LB/LH sign-extended, LBU/LHU zero-extended, LW unchanged, into yanit_veri.
REQ-024 SHALL in YANIT assert yanit_gecerli for exactly one cycle, holding yanit_veri/yanit_hata stable during it; outside YANIT both SHALL be 0.
REQ-025 SHALL have latency: accept at edge N, bellege_yaz during cycle N..N+1, yanit_gecerli during cycle N+1..N+2; one request per 3 cycles maximum.

Reset
REQ-026 SHALL on rst asserted, immediately and regardless of clock, go to BOSTA with istek_hazir=1 and bellege_yaz, yanit_gecerli, yanit_hata=0, yanit_veri, bellek_adres, bellek_veri=0.
REQ-027 SHALL drop any in-flight request on reset mid-operation, with no write issued after rst rises and no response produced.

Configuration
REQ-028 SHALL, with ADRES_SINIR_KONTROL_EN defined, additionally fault any request with istek_adres >= 4*KELIME_SAYISI (per REQ-020).
REQ-029 SHALL, without ADRES_SINIR_KONTROL_EN, ignore upper address bits so accesses wrap modulo 4*KELIME_SAYISI bytes.

Verification
REQ-030 SHALL cover: memory word 5 = 0x11223344; SB adres=0x15 veri=0xAB -> one-cycle bellege_yaz, bellek_adres=5, bellek_veri=0x1122AB44.
REQ-031 SHALL cover: word 5 = 0x80FF7F01; LB 0x16 -> yanit_veri=0xFFFFFFFF; LBU 0x16 -> 0x000000FF; LH 0x16 -> 0xFFFF80FF; LW 0x14 -> 0x80FF7F01.
REQ-032 SHALL cover: LW adres=0x22 and SH adres=0x13 -> yanit_hata=1, yanit_veri=0, bellege_yaz never 1; funct3=011 load -> fault.
REQ-033 SHALL cover: adres=0x404 SW with macro -> fault, no write; without macro -> write to bellek_adres=1.
REQ-034 SHALL cover: rst pulsed during ERISIM of an SW -> bellege_yaz drops asynchronously, no yanit_gecerli, istek_hazir=1 next cycle.
REQ-035 SHALL cover: istek_gecerli held high for back-to-back loads -> accepts exactly every third edge, yanit_gecerli exactly one cycle each.

Source files
------------

// File: rtl/yukle_sakla_birimi_if.sv
// -----------------------------------------------------------------------------
// yukle_sakla_birimi_if
// Core-side request/response bundle of the load/store unit.
//   istek_gecerli  core -> unit  request valid
//   istek_hazir    unit -> core  unit can accept a request
//   istek_yaz      core -> unit  1 = store, 0 = load
//   istek_funct3   core -> unit  RISC-V funct3 (size/sign)
//   istek_adres    core -> unit  byte address
//   istek_veri     core -> unit  store data, LSB-aligned
//   yanit_gecerli  unit -> core  one-cycle response pulse
//   yanit_veri     unit -> core  load result (0 for stores and faults)
//   yanit_hata     unit -> core  request faulted, valid with yanit_gecerli
// Modports: master = core side, slave = load/store unit.
// -----------------------------------------------------------------------------
interface yukle_sakla_birimi_if;
  logic        istek_gecerli;
  logic        istek_hazir;
  logic        istek_yaz;
  logic [2:0]  istek_funct3;
  logic [31:0] istek_adres;
  logic [31:0] istek_veri;
  logic        yanit_gecerli;
  logic [31:0] yanit_veri;
  logic        yanit_hata;

  modport master (
    output istek_gecerli, istek_yaz, istek_funct3, istek_adres, istek_veri,
    input  istek_hazir, yanit_gecerli, yanit_veri, yanit_hata
  );

  modport slave (
    input  istek_gecerli, istek_yaz, istek_funct3, istek_adres, istek_veri,
    output istek_hazir, yanit_gecerli, yanit_veri, yanit_hata
  );
endinterface

// File: rtl/yukle_sakla_birimi.sv
// -----------------------------------------------------------------------------
// yukle_sakla_birimi
// RISC-V load/store unit in front of a word-organised data memory with a
// combinational read port. Sub-word stores are done as read-modify-write in
// a single access cycle. Flow: BOSTA -> ERISIM -> YANIT -> BOSTA; faulted
// requests skip ERISIM and never touch memory.
//
// Ports:
//   clk                 clock, rising edge
//   rst                 asynchronous active-high reset
//   bus                 core request/response bundle (slave modport)
//   bellek_adres        word index to data memory (0 outside ERISIM)
//   bellek_veri         merged write word to data memory
//   bellege_yaz         data memory write enable
//   bellek_veri_cikisi  combinational read word from data memory
//
// Parameter KELIME_SAYISI: memory depth in 32-bit words (power of two).
// Optional feature macro ADRES_SINIR_KONTROL_EN: when defined, addresses at or
// beyond 4*KELIME_SAYISI fault; otherwise they wrap modulo the memory size.
// -----------------------------------------------------------------------------
module yukle_sakla_birimi #(
  parameter int KELIME_SAYISI = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  yukle_sakla_birimi_if.slave     bus,
  output logic [31:0]             bellek_adres,
  output logic [31:0]             bellek_veri,
  output logic                    bellege_yaz,
  input  logic [31:0]             bellek_veri_cikisi
);

  // Word-index mask; also serves as the highest legal word index.
  localparam logic [31:0] ADRES_MASKE = 32'(KELIME_SAYISI - 1);

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    ERISIM = 2'd1,
    YANIT  = 2'd2
  } durum_t;

  durum_t      durum, sonraki_durum;

  logic        r_yaz;
  logic [2:0]  r_funct3;
  logic [31:0] r_adres;
  logic [31:0] r_veri;
  logic        r_hata;
  logic [31:0] r_yanit_veri;

  logic        kabul;
  logic        istek_hatali;
  logic [7:0]  bayt;
  logic [15:0] yarim;
  logic [31:0] yuklenen_deger;
  logic [31:0] birlesik_kelime;

  assign kabul = (durum == BOSTA) && bus.istek_gecerli;

  // Fault classification of the incoming request, evaluated in BOSTA.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    istek_hatali = 1'b0;
    case (bus.istek_funct3)
      3'b000:  istek_hatali = 1'b0;                                  // LB / SB
      3'b001:  istek_hatali = bus.istek_adres[0];                    // LH / SH
      3'b010:  istek_hatali = |bus.istek_adres[1:0];                 // LW / SW
      3'b100:  istek_hatali = bus.istek_yaz;                         // LBU only
      3'b101:  istek_hatali = bus.istek_yaz | bus.istek_adres[0];    // LHU only
      default: istek_hatali = 1'b1;
    endcase
`ifdef ADRES_SINIR_KONTROL_EN
    if ((bus.istek_adres >> 2) > ADRES_MASKE) istek_hatali = 1'b1;
`endif
  end

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) durum <= BOSTA;
    else     durum <= sonraki_durum;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    sonraki_durum = durum;
    case (durum)
      BOSTA:   if (bus.istek_gecerli) sonraki_durum = istek_hatali ? YANIT : ERISIM;
      ERISIM:  sonraki_durum = YANIT;
      YANIT:   sonraki_durum = BOSTA;
      default: sonraki_durum = BOSTA;
    endcase
  end

  // ------------------------------------------------------ request / load data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_yaz        <= 1'b0;
      r_funct3     <= 3'b000;
      r_adres      <= '0;
      r_veri       <= '0;
      r_hata       <= 1'b0;
      r_yanit_veri <= '0;
    end else if (kabul) begin
      r_yaz        <= bus.istek_yaz;
      r_funct3     <= bus.istek_funct3;
      r_adres      <= bus.istek_adres;
      r_veri       <= bus.istek_veri;
      r_hata       <= istek_hatali;
      // Cleared here so stores and faults answer with zero data.
      r_yanit_veri <= '0;
    end else if (durum == ERISIM && !r_yaz) begin
      r_yanit_veri <= yuklenen_deger;
    end
  end

  // Lane extraction for loads and lane merge for stores.
  always_comb begin
    bayt            = bellek_veri_cikisi[8*r_adres[1:0] +: 8];
    yarim           = bellek_veri_cikisi[16*r_adres[1] +: 16];
    yuklenen_deger  = bellek_veri_cikisi;
    birlesik_kelime = bellek_veri_cikisi;
    case (r_funct3)
      3'b000:  yuklenen_deger = {{24{bayt[7]}}, bayt};
      3'b001:  yuklenen_deger = {{16{yarim[15]}}, yarim};
      3'b100:  yuklenen_deger = {24'h0, bayt};
      3'b101:  yuklenen_deger = {16'h0, yarim};
      default: yuklenen_deger = bellek_veri_cikisi;
    endcase
    case (r_funct3)
      3'b000:  birlesik_kelime[8*r_adres[1:0] +: 8] = r_veri[7:0];
      3'b001:  birlesik_kelime[16*r_adres[1] +: 16] = r_veri[15:0];
      default: birlesik_kelime = r_veri;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    bus.istek_hazir   = 1'b0;
    bus.yanit_gecerli = 1'b0;
    bus.yanit_veri    = '0;
    bus.yanit_hata    = 1'b0;
    bellek_adres      = '0;
    bellek_veri       = '0;
    bellege_yaz       = 1'b0;
    case (durum)
      BOSTA: bus.istek_hazir = 1'b1;
      ERISIM: begin
        // Upper address bits are masked off, so out-of-range accesses wrap.
        bellek_adres = (r_adres >> 2) & ADRES_MASKE;
        if (r_yaz) begin
          bellege_yaz = 1'b1;
          bellek_veri = birlesik_kelime;
        end
      end
      YANIT: begin
        bus.yanit_gecerli = 1'b1;
        bus.yanit_veri    = r_yanit_veri;
        bus.yanit_hata    = r_hata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_yukle_sakla_birimi.sv
// -----------------------------------------------------------------------------
// tb_yukle_sakla_birimi
// Directed bench for yukle_sakla_birimi: a table of single requests with
// hand-computed results, plus hand-written sequences for reset state, reset
// during a store access and back-to-back loads with a held request.
// A simple word memory model sits on the memory port.
// -----------------------------------------------------------------------------
module tb_yukle_sakla_birimi;

  localparam int KS = 256;

  logic        clk;
  logic        rst;
  logic [31:0] bellek_adres;
  logic [31:0] bellek_veri;
  logic        bellege_yaz;
  logic [31:0] bellek_veri_cikisi;

  logic [31:0] mem [KS];
  logic        yukle_en;
  logic [7:0]  yukle_idx;
  logic [31:0] yukle_deger;

  int toplam;
  int hata_sayisi;

  yukle_sakla_birimi_if bus ();

  yukle_sakla_birimi #(.KELIME_SAYISI(KS)) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .bellek_adres       (bellek_adres),
    .bellek_veri        (bellek_veri),
    .bellege_yaz        (bellege_yaz),
    .bellek_veri_cikisi (bellek_veri_cikisi)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on rising edge; yukle_en is the
  // bench's own preload port.
  assign bellek_veri_cikisi = mem[bellek_adres[7:0]];

  always @(posedge clk) begin
    if (bellege_yaz) mem[bellek_adres[7:0]] <= bellek_veri;
    if (yukle_en)    mem[yukle_idx]         <= yukle_deger;
  end

  typedef struct {
    logic        on_yukle;
    logic [7:0]  idx;
    logic [31:0] on_deger;
    logic        yaz;
    logic [2:0]  f3;
    logic [31:0] adres;
    logic [31:0] veri;
    logic        bek_hata;
    logic        bek_yazma;
    logic [31:0] bek_badres;
    logic [31:0] bek_bveri;
    logic [31:0] bek_yveri;
  } vektor_t;

  vektor_t vt [18];

  task automatic check(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    toplam++;
    if (gercek !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", ad, gercek, beklenen);
    end
  endtask

  // Called at a negedge; returns at the negedge after the preload edge.
  task automatic on_yukle(input logic [7:0] idx, input logic [31:0] deger);
    yukle_idx   = idx;
    yukle_deger = deger;
    yukle_en    = 1'b1;
    @(negedge clk);
    yukle_en    = 1'b0;
  endtask

  // Called at a negedge with the unit idle; returns four negedges later.
  task automatic vektor_uygula(input int n, input vektor_t v);
    int          yazma_sayisi;
    int          yanit_sayisi;
    int          yanit_dongu;
    logic [31:0] g_badres;
    logic [31:0] g_bveri;
    logic [31:0] g_yveri;
    logic        g_hata;
    if (v.on_yukle) on_yukle(v.idx, v.on_deger);
    check($sformatf("v%0d istek_hazir idle", n), 32'(bus.istek_hazir), 32'd1);
    bus.istek_yaz     = v.yaz;
    bus.istek_funct3  = v.f3;
    bus.istek_adres   = v.adres;
    bus.istek_veri    = v.veri;
    bus.istek_gecerli = 1'b1;
    @(posedge clk);
    #1 bus.istek_gecerli = 1'b0;
    yazma_sayisi = 0;
    yanit_sayisi = 0;
    yanit_dongu  = -1;
    g_badres     = 32'hFFFF_FFFF;
    g_bveri      = '0;
    g_yveri      = 32'hFFFF_FFFF;
    g_hata       = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) g_badres = bellek_adres;
      if (bellege_yaz) begin
        yazma_sayisi++;
        g_bveri = bellek_veri;
      end
      if (bus.yanit_gecerli) begin
        yanit_sayisi++;
        yanit_dongu = c;
        g_yveri     = bus.yanit_veri;
        g_hata      = bus.yanit_hata;
      end
    end
    check($sformatf("v%0d yanit pulses", n), 32'(yanit_sayisi), 32'd1);
    check($sformatf("v%0d yanit cycle", n), 32'(yanit_dongu), v.bek_hata ? 32'd0 : 32'd1);
    check($sformatf("v%0d yanit_hata", n), 32'(g_hata), 32'(v.bek_hata));
    check($sformatf("v%0d yanit_veri", n), g_yveri, v.bek_yveri);
    check($sformatf("v%0d write count", n), 32'(yazma_sayisi), 32'(v.bek_yazma));
    check($sformatf("v%0d bellek_adres", n), g_badres, v.bek_badres);
    if (v.bek_yazma) check($sformatf("v%0d bellek_veri", n), g_bveri, v.bek_bveri);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hazir_maske;
    logic [31:0] yanit_maske;
    int          yaz_say;
    int          yan_say;

    toplam      = 0;
    hata_sayisi = 0;
    clk         = 1'b0;
    rst         = 1'b1;
    yukle_en    = 1'b0;
    yukle_idx   = '0;
    yukle_deger = '0;
    for (int i = 0; i < KS; i++) mem[i] = '0;
    bus.istek_gecerli = 1'b0;
    bus.istek_yaz     = 1'b0;
    bus.istek_funct3  = 3'b000;
    bus.istek_adres   = '0;
    bus.istek_veri    = '0;

    //               pre  idx     pre value      yaz  f3      adres      veri           hata yazma badres  bveri          yveri
    vt[0]  = '{1'b1, 8'd5,   32'h11223344, 1'b1, 3'b000, 32'h15,  32'h000000AB, 1'b0, 1'b1, 32'd5,   32'h1122AB44, 32'h0};
    vt[1]  = '{1'b0, 8'd0,   32'h0,        1'b0, 3'b010, 32'h14,  32'h0,        1'b0, 1'b0, 32'd5,   32'h0,        32'h1122AB44};
    vt[2]  = '{1'b1, 8'd5,   32'h80FF7F01, 1'b0, 3'b000, 32'h16,  32'h0,        1'b0, 1'b0, 32'd5,   32'h0,        32'hFFFFFFFF};
    vt[3]  = '{1'b0, 8'd0,   32'h0,        1'b0, 3'b100, 32'h16,  32'h0,        1'b0, 1'b0, 32'd5,   32'h0,        32'h000000FF};
    vt[4]  = '{1'b0, 8'd0,   32'h0,        1'b0, 3'b001, 32'h16,  32'h0,        1'b0, 1'b0, 32'd5,   32'h0,        32'hFFFF80FF};
    vt[5]  = '{1'b0, 8'd0,   32'h0,        1'b0, 3'b010, 32'h14,  32'h0,        1'b0, 1'b0, 32'd5,   32'h0,        32'h80FF7F01};
    vt[6]  = '{1'b0, 8'd0,   32'h0,        1'b0, 3'b101, 32'h14,  32'h0,        1'b0, 1'b0, 32'd5,   32'h0,        32'h00007F01};
    vt[7]  = '{1'b0, 8'd0,   32'h0,        1'b0, 3'b000, 32'h15,  32'h0,        1'b0, 1'b0, 32'd5,   32'h0,        32'h0000007F};
    vt[8]  = '{1'b0, 8'd0,   32'h0,        1'b0, 3'b010, 32'h22,  32'h0,        1'b1, 1'b0, 32'd0,   32'h0,        32'h0};
    vt[9]  = '{1'b0, 8'd0,   32'h0,        1'b1, 3'b001, 32'h13,  32'h00001234, 1'b1, 1'b0, 32'd0,   32'h0,        32'h0};
    vt[10] = '{1'b0, 8'd0,   32'h0,        1'b0, 3'b011, 32'h14,  32'h0,        1'b1, 1'b0, 32'd0,   32'h0,        32'h0};
    vt[11] = '{1'b1, 8'd4,   32'hDEADBEEF, 1'b1, 3'b001, 32'h12,  32'h1234ABCD, 1'b0, 1'b1, 32'd4,   32'hABCDBEEF, 32'h0};
`ifdef ADRES_SINIR_KONTROL_EN
    vt[12] = '{1'b1, 8'd1,   32'h0,        1'b1, 3'b010, 32'h404, 32'hCAFEF00D, 1'b1, 1'b0, 32'd0,   32'h0,        32'h0};
`else
    vt[12] = '{1'b1, 8'd1,   32'h0,        1'b1, 3'b010, 32'h404, 32'hCAFEF00D, 1'b0, 1'b1, 32'd1,   32'hCAFEF00D, 32'h0};
`endif
    vt[13] = '{1'b1, 8'd8,   32'h0,        1'b1, 3'b000, 32'h23,  32'h00000055, 1'b0, 1'b1, 32'd8,   32'h55000000, 32'h0};
    vt[14] = '{1'b0, 8'd0,   32'h0,        1'b1, 3'b100, 32'h14,  32'h000000AA, 1'b1, 1'b0, 32'd0,   32'h0,        32'h0};
    vt[15] = '{1'b0, 8'd0,   32'h0,        1'b0, 3'b001, 32'h15,  32'h0,        1'b1, 1'b0, 32'd0,   32'h0,        32'h0};
    vt[16] = '{1'b1, 8'd255, 32'h80011234, 1'b0, 3'b101, 32'h3FE, 32'h0,        1'b0, 1'b0, 32'd255, 32'h0,        32'h00008001};
    vt[17] = '{1'b0, 8'd0,   32'h0,        1'b0, 3'b010, 32'h20,  32'h0,        1'b0, 1'b0, 32'd8,   32'h0,        32'h55000000};

    // ---- reset state, checked with no clock edge seen yet
    #2;
    check("rst istek_hazir",   32'(bus.istek_hazir),   32'd1);
    check("rst bellege_yaz",   32'(bellege_yaz),       32'd0);
    check("rst yanit_gecerli", 32'(bus.yanit_gecerli), 32'd0);
    check("rst yanit_hata",    32'(bus.yanit_hata),    32'd0);
    check("rst yanit_veri",    bus.yanit_veri,         32'd0);
    check("rst bellek_adres",  bellek_adres,           32'd0);
    check("rst bellek_veri",   bellek_veri,            32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ---- table-driven single requests
    for (int i = 0; i < 18; i++) vektor_uygula(i, vt[i]);

    // ---- reset pulsed during ERISIM of a store
    on_yukle(8'd8, 32'h01020304);
    bus.istek_yaz     = 1'b1;
    bus.istek_funct3  = 3'b010;
    bus.istek_adres   = 32'h20;
    bus.istek_veri    = 32'hFFFFFFFF;
    bus.istek_gecerli = 1'b1;
    @(posedge clk);
    #1 bus.istek_gecerli = 1'b0;
    @(negedge clk);
    check("mid-rst write before rst", 32'(bellege_yaz), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid-rst bellege_yaz async", 32'(bellege_yaz),     32'd0);
    check("mid-rst bellek_adres async", bellek_adres,        32'd0);
    check("mid-rst istek_hazir async", 32'(bus.istek_hazir), 32'd1);
    #1 rst = 1'b0;
    yaz_say = 0;
    yan_say = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) check("mid-rst istek_hazir next cycle", 32'(bus.istek_hazir), 32'd1);
      if (bellege_yaz) yaz_say++;
      if (bus.yanit_gecerli) yan_say++;
    end
    check("mid-rst writes after rst", 32'(yaz_say), 32'd0);
    check("mid-rst responses",        32'(yan_say), 32'd0);
    check("mid-rst memory word 8",    mem[8],       32'h01020304);

    // ---- back-to-back loads with istek_gecerli held high
    on_yukle(8'd5, 32'h80FF7F01);
    hazir_maske = '0;
    yanit_maske = '0;
    bus.istek_yaz     = 1'b0;
    bus.istek_funct3  = 3'b010;
    bus.istek_adres   = 32'h14;
    bus.istek_veri    = '0;
    bus.istek_gecerli = 1'b1;
    for (int k = 0; k < 9; k++) begin
      hazir_maske[k] = bus.istek_hazir;
      yanit_maske[k] = bus.yanit_gecerli;
      if (bus.yanit_gecerli)
        check($sformatf("b2b yanit_veri k%0d", k), bus.yanit_veri, 32'h80FF7F01);
      @(negedge clk);
    end
    bus.istek_gecerli = 1'b0;
    check("b2b accept pattern", hazir_maske, 32'b001001001);
    check("b2b yanit pattern",  yanit_maske, 32'b100100100);

    $display("End of test - %0d assertions evaluated, %0d failures", toplam, hata_sayisi);
    $finish;
  end

endmodule
